// File: rtl/vstu_commit_tracker.sv
// Tracks AXI write bursts per in-flight vector store and pulses an in-order,
// one-hot completion (with error status) once every burst of a store has its B response.
module vstu_commit_tracker #(
    parameter int unsigned NrVInsn    = 8,
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned CntWidth   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       insn_valid_i,
    input  logic [$clog2(NrVInsn)-1:0] insn_id_i,
    input  logic                       insn_empty_i,
    output logic                       insn_ready_o,
    input  logic                       aw_issued_i,
    input  logic                       aw_last_i,
    input  logic                       b_valid_i,
    input  logic [1:0]                 b_resp_i,
    output logic                       b_ready_o,
    output logic [NrVInsn-1:0]         vinsn_done_o,
    output logic                       done_err_o,
    output logic                       pending_o
);

    localparam int unsigned IdWidth  = $clog2(NrVInsn);
    localparam int unsigned PtrWidth = $clog2(QueueDepth);
    localparam int unsigned OccWidth = PtrWidth + 1;
    localparam logic [OccWidth-1:0] OccFull = OccWidth'(QueueDepth);

    typedef struct packed {
        logic [IdWidth-1:0]  id;
        logic [CntWidth-1:0] issued;
        logic [CntWidth-1:0] acked;
        logic                all_issued;
        logic                err;
    } entry_t;

    // Applies this cycle's AW and B events to one entry's counters and flags.
    function automatic entry_t update_entry(input entry_t e, input logic aw, input logic last,
                                            input logic b, input logic b_err);
        entry_t r;
        r            = e;
        r.issued     = e.issued + CntWidth'(aw);
        r.all_issued = e.all_issued | (aw & last);
        r.acked      = e.acked + CntWidth'(b);
        r.err        = e.err | (b & b_err);
        return r;
    endfunction

    entry_t                entry_reg  [QueueDepth];
    entry_t                entry_next [QueueDepth];
    logic [QueueDepth-1:0] valid_reg, valid_next;
    logic [PtrWidth-1:0]   accept_pnt_reg, accept_pnt_next;
    logic [PtrWidth-1:0]   issue_pnt_reg, issue_pnt_next;
    logic [PtrWidth-1:0]   commit_pnt_reg, commit_pnt_next;
    logic [OccWidth-1:0]   cnt_reg, cnt_next;
    logic [NrVInsn-1:0]    done_reg, done_next;
    logic                  done_err_reg, done_err_next;

    logic   accept, aw_fire, b_fire, pop;
    logic   head_valid, issue_open, issue_skip;
    entry_t head_reg, head_next, issue_reg, new_entry;
    logic   unused_resp;

    assign unused_resp = b_resp_i[0];

    assign insn_ready_o = (cnt_reg != OccFull);
    assign pending_o    = (cnt_reg != '0);
    assign accept       = insn_valid_i && insn_ready_o;

    assign head_reg   = entry_reg[commit_pnt_reg];
    assign head_valid = valid_reg[commit_pnt_reg];
    assign issue_reg  = entry_reg[issue_pnt_reg];
    assign issue_open = valid_reg[issue_pnt_reg] && !issue_reg.all_issued;
    // Empty stores never see an AW, so the issue pointer steps over them.
    assign issue_skip = valid_reg[issue_pnt_reg] && issue_reg.all_issued;
    assign aw_fire    = aw_issued_i && issue_open;

    // Registered state only, so a burst cannot be acked in its own AW cycle.
    assign b_ready_o = head_valid && (head_reg.acked < head_reg.issued);
    assign b_fire    = b_valid_i && b_ready_o;

    always_comb begin
        new_entry            = '0;
        new_entry.id         = insn_id_i;
        new_entry.all_issued = insn_empty_i;
    end

    for (genvar gi = 0; gi < QueueDepth; gi++) begin : g_entry
        logic acc_hit, aw_hit, b_hit;
        assign acc_hit = accept && (accept_pnt_reg == PtrWidth'(gi));
        assign aw_hit  = aw_fire && (issue_pnt_reg == PtrWidth'(gi));
        assign b_hit   = b_fire && (commit_pnt_reg == PtrWidth'(gi));
        assign entry_next[gi] = acc_hit ? new_entry
                              : update_entry(entry_reg[gi], aw_hit, aw_last_i, b_hit, b_resp_i[1]);
        assign valid_next[gi] = acc_hit
                              | (valid_reg[gi] & ~(pop && (commit_pnt_reg == PtrWidth'(gi))));
    end

    // Completion looks at next-state counts so the final B retires the store immediately.
    assign head_next = entry_next[commit_pnt_reg];
    assign pop = head_valid && head_next.all_issued && (head_next.acked == head_next.issued);

    always_comb begin
        accept_pnt_next = accept_pnt_reg + PtrWidth'(accept);
        commit_pnt_next = commit_pnt_reg + PtrWidth'(pop);
        issue_pnt_next  = issue_pnt_reg;
        if ((aw_fire && aw_last_i) || issue_skip) begin
            issue_pnt_next = issue_pnt_reg + PtrWidth'(1);
        end
        cnt_next      = cnt_reg + OccWidth'(accept) - OccWidth'(pop);
        done_next     = '0;
        done_err_next = 1'b0;
        if (pop) begin
            done_next     = NrVInsn'(1) << head_next.id;
            done_err_next = head_next.err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QueueDepth; i++) begin
                entry_reg[i] <= '0;
            end
            valid_reg      <= '0;
            accept_pnt_reg <= '0;
            issue_pnt_reg  <= '0;
            commit_pnt_reg <= '0;
            cnt_reg        <= '0;
            done_reg       <= '0;
            done_err_reg   <= 1'b0;
        end else begin
            entry_reg      <= entry_next;
            valid_reg      <= valid_next;
            accept_pnt_reg <= accept_pnt_next;
            issue_pnt_reg  <= issue_pnt_next;
            commit_pnt_reg <= commit_pnt_next;
            cnt_reg        <= cnt_next;
            done_reg       <= done_next;
            done_err_reg   <= done_err_next;
        end
    end

    assign vinsn_done_o = done_reg;
    assign done_err_o   = done_err_reg;

    // An AW with nothing left to issue, or one that would wrap the burst counter, is a caller bug.
    a_aw_has_target: assert property (@(posedge clk_i) disable iff (!rst_ni)
        aw_issued_i |-> issue_open);
    a_aw_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        aw_fire |-> (issue_reg.issued != '1));

endmodule

// File: tb/tb_vstu_commit_tracker.sv
// Directed bench for vstu_commit_tracker: hand-computed expectations, one line per check.
module tb_vstu_commit_tracker;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       insn_valid_i;
    logic [2:0] insn_id_i;
    logic       insn_empty_i;
    logic       insn_ready_o;
    logic       aw_issued_i;
    logic       aw_last_i;
    logic       b_valid_i;
    logic [1:0] b_resp_i;
    logic       b_ready_o;
    logic [7:0] vinsn_done_o;
    logic       done_err_o;
    logic       pending_o;

    int checks = 0;
    int errors = 0;

    vstu_commit_tracker #(.NrVInsn(8), .QueueDepth(4), .CntWidth(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .insn_valid_i (insn_valid_i),
        .insn_id_i    (insn_id_i),
        .insn_empty_i (insn_empty_i),
        .insn_ready_o (insn_ready_o),
        .aw_issued_i  (aw_issued_i),
        .aw_last_i    (aw_last_i),
        .b_valid_i    (b_valid_i),
        .b_resp_i     (b_resp_i),
        .b_ready_o    (b_ready_o),
        .vinsn_done_o (vinsn_done_o),
        .done_err_o   (done_err_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(insn_ready_o), 32'd1);
        check({tag, "_bready"},  32'(b_ready_o),    32'd0);
        check({tag, "_done"},    32'(vinsn_done_o), 32'd0);
        check({tag, "_err"},     32'(done_err_o),   32'd0);
        check({tag, "_pending"}, 32'(pending_o),    32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        insn_valid_i = 1'b0;
        insn_id_i    = '0;
        insn_empty_i = 1'b0;
        aw_issued_i  = 1'b0;
        aw_last_i    = 1'b0;
        b_valid_i    = 1'b0;
        b_resp_i     = 2'b00;
        repeat (2) @(posedge clk_i);
        #2;
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        cyc();

        // 1: id 3, three bursts, three OKAY responses
        insn_valid_i = 1'b1; insn_id_i = 3'd3; cyc();
        insn_valid_i = 1'b0;
        check("t1_pending", 32'(pending_o), 32'd1);
        check("t1_bready_noaw", 32'(b_ready_o), 32'd0);
        aw_issued_i = 1'b1; cyc();
        check("t1_bready_aw1", 32'(b_ready_o), 32'd1);
        cyc();
        aw_last_i = 1'b1; cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0;
        b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_bready_b%0d", i), 32'(b_ready_o), 32'd1);
            cyc();
        end
        b_valid_i = 1'b0;
        check("t1_done", 32'(vinsn_done_o), 32'h08);
        check("t1_err", 32'(done_err_o), 32'd0);
        cyc();
        check("t1_done_pulse", 32'(vinsn_done_o), 32'h00);
        check("t1_idle", 32'(pending_o), 32'd0);

        // 2: id 1 (2 bursts), id 2 (1 burst), delayed Bs, in-order completion
        insn_valid_i = 1'b1; insn_id_i = 3'd1; cyc();
        insn_id_i = 3'd2; aw_issued_i = 1'b1; cyc();
        insn_valid_i = 1'b0; aw_last_i = 1'b1; cyc();
        cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0;
        cyc();
        check("t2_wait0", 32'(vinsn_done_o), 32'h00);
        cyc();
        check("t2_wait1", 32'(vinsn_done_o), 32'h00);
        b_valid_i = 1'b1; cyc();
        check("t2_after_b1", 32'(vinsn_done_o), 32'h00);
        cyc();
        check("t2_done1", 32'(vinsn_done_o), 32'h02);
        check("t2_bready_id2", 32'(b_ready_o), 32'd1);
        cyc();
        b_valid_i = 1'b0;
        check("t2_done2", 32'(vinsn_done_o), 32'h04);
        cyc();
        check("t2_quiet", 32'(vinsn_done_o), 32'h00);

        // 3: id 5, OKAY then SLVERR
        insn_valid_i = 1'b1; insn_id_i = 3'd5; cyc();
        insn_valid_i = 1'b0; aw_issued_i = 1'b1; cyc();
        aw_last_i = 1'b1; cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0;
        b_valid_i = 1'b1; b_resp_i = 2'b00; cyc();
        check("t3_mid", 32'(vinsn_done_o), 32'h00);
        b_resp_i = 2'b10; cyc();
        b_valid_i = 1'b0; b_resp_i = 2'b00;
        check("t3_done", 32'(vinsn_done_o), 32'h20);
        check("t3_err", 32'(done_err_o), 32'd1);
        cyc();
        check("t3_err_pulse", 32'(done_err_o), 32'd0);

        // 4: fill the queue, no bypass on pop, then drain
        insn_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            insn_id_i = 3'(i);
            cyc();
        end
        insn_id_i = 3'd4;
        check("t4_full", 32'(insn_ready_o), 32'd0);
        aw_issued_i = 1'b1; aw_last_i = 1'b1; cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0;
        b_valid_i = 1'b1;
        check("t4_full_on_pop", 32'(insn_ready_o), 32'd0);
        cyc();
        b_valid_i = 1'b0;
        check("t4_done0", 32'(vinsn_done_o), 32'h01);
        check("t4_ready_after_pop", 32'(insn_ready_o), 32'd1);
        cyc();
        insn_valid_i = 1'b0;
        check("t4_refull", 32'(insn_ready_o), 32'd0);
        for (int k = 1; k < 5; k++) begin
            aw_issued_i = 1'b1; aw_last_i = 1'b1; cyc();
            aw_issued_i = 1'b0; aw_last_i = 1'b0;
            b_valid_i = 1'b1; cyc();
            b_valid_i = 1'b0;
            check($sformatf("t4_drain%0d", k), 32'(vinsn_done_o), 32'(8'h01 << k));
        end
        check("t4_empty", 32'(pending_o), 32'd0);

        // 5: empty id 0 between active id 7 and id 6
        insn_valid_i = 1'b1; insn_id_i = 3'd7; cyc();
        insn_id_i = 3'd0; insn_empty_i = 1'b1; cyc();
        insn_id_i = 3'd6; insn_empty_i = 1'b0; cyc();
        insn_valid_i = 1'b0;
        aw_issued_i = 1'b1; cyc();
        aw_last_i = 1'b1; cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0; cyc();
        aw_issued_i = 1'b1; aw_last_i = 1'b1; cyc();
        aw_issued_i = 1'b0; aw_last_i = 1'b0;
        check("t5_no_early", 32'(vinsn_done_o), 32'h00);
        b_valid_i = 1'b1; cyc();
        check("t5_mid", 32'(vinsn_done_o), 32'h00);
        cyc();
        check("t5_done7", 32'(vinsn_done_o), 32'h80);
        check("t5_stall_on_empty", 32'(b_ready_o), 32'd0);
        cyc();
        check("t5_done0", 32'(vinsn_done_o), 32'h01);
        check("t5_bready_id6", 32'(b_ready_o), 32'd1);
        cyc();
        b_valid_i = 1'b0;
        check("t5_done6", 32'(vinsn_done_o), 32'h40);

        // 6: early B stalls until the first AW; async reset mid-store
        b_valid_i = 1'b1;
        check("t6_bready_empty", 32'(b_ready_o), 32'd0);
        insn_valid_i = 1'b1; insn_id_i = 3'd4; cyc();
        insn_valid_i = 1'b0;
        check("t6_bready_noaw0", 32'(b_ready_o), 32'd0);
        cyc();
        check("t6_bready_noaw1", 32'(b_ready_o), 32'd0);
        aw_issued_i = 1'b1; cyc();
        aw_issued_i = 1'b0;
        check("t6_bready_aw", 32'(b_ready_o), 32'd1);
        cyc();
        b_valid_i = 1'b0;
        aw_issued_i = 1'b1; cyc();
        aw_issued_i = 1'b0;
        check("t6_pending", 32'(pending_o), 32'd1);
        check("t6_bready_second", 32'(b_ready_o), 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        cyc();
        insn_valid_i = 1'b1; insn_id_i = 3'd2; insn_empty_i = 1'b1; cyc();
        insn_valid_i = 1'b0; insn_empty_i = 1'b0;
        check("t6_empty_n1", 32'(vinsn_done_o), 32'h00);
        cyc();
        check("t6_empty_n2", 32'(vinsn_done_o), 32'h04);
        check("t6_final_idle", 32'(pending_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
